// File: rtl/ctrl_resolve.sv
// Control-transfer resolve: mispredict redirect with squash window,
// plus a small FIFO feeding branch-predictor updates.
module ctrl_resolve #(
    parameter int SIZE_PC      = 32,
    parameter int SIZE_ROB_LOG = 7,
    parameter int SIZE_CTI_LOG = 4,
    parameter int UPD_DEPTH    = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    exeValid_i,
    input  logic [SIZE_PC-1:0]      pc_i,
    input  logic [SIZE_PC-1:0]      nextPC_i,
    input  logic                    direction_i,
    input  logic [7:0]              flags_i,
    input  logic [SIZE_ROB_LOG-1:0] robId_i,
    input  logic [SIZE_CTI_LOG-1:0] ctiId_i,
    output logic                    recoverFlag_o,
    output logic [SIZE_PC-1:0]      recoverPC_o,
    output logic [SIZE_ROB_LOG-1:0] recoverRobId_o,
    output logic [SIZE_CTI_LOG-1:0] recoverCtiId_o,
    output logic                    squash_o,
    output logic                    updValid_o,
    output logic [SIZE_PC-1:0]      updPC_o,
    output logic [SIZE_PC-1:0]      updTarget_o,
    output logic                    updDir_o,
    output logic                    updCond_o,
    input  logic                    updReady_i,
    output logic [$clog2(UPD_DEPTH):0] updCount_o,
    output logic                    overflow_o
);

    localparam int AW  = $clog2(UPD_DEPTH);
    localparam int CW  = AW + 1;
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [DCW-1:0]   r_drainCnt;
    logic [DCW-1:0]   w_drainCntNext;

    logic             w_accept;
    logic             w_mispredict;

    assign w_accept     = exeValid_i & flags_i[5] & (r_state == IDLE);
    assign w_mispredict = w_accept & flags_i[0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_drainCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_drainCnt <= w_drainCntNext;
        end
    end

    // Next-state logic
    always_comb begin
        w_stateNext    = r_state;
        w_drainCntNext = r_drainCnt;
        unique case (r_state)
            IDLE: begin
                if (w_mispredict) w_stateNext = REDIRECT;
            end
            REDIRECT: begin
                w_stateNext    = DRAIN;
                w_drainCntNext = DCW'(DRAIN_CYCLES - 1);
            end
            DRAIN: begin
                if (r_drainCnt == '0) w_stateNext = IDLE;
                else w_drainCntNext = r_drainCnt - 1'b1;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        recoverFlag_o = (r_state == REDIRECT);
        squash_o      = (r_state != IDLE);
    end

    logic [SIZE_PC-1:0]      r_recPC;
    logic [SIZE_ROB_LOG-1:0] r_recRob;
    logic [SIZE_CTI_LOG-1:0] r_recCti;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_recPC  <= '0;
            r_recRob <= '0;
            r_recCti <= '0;
        end else if (w_mispredict) begin
            r_recPC  <= nextPC_i;
            r_recRob <= robId_i;
            r_recCti <= ctiId_i;
        end
    end

    assign recoverPC_o    = r_recPC;
    assign recoverRobId_o = r_recRob;
    assign recoverCtiId_o = r_recCti;

    logic [SIZE_PC-1:0] r_memPC   [UPD_DEPTH];
    logic [SIZE_PC-1:0] r_memTgt  [UPD_DEPTH];
    logic               r_memDir  [UPD_DEPTH];
    logic               r_memCond [UPD_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_pushOk;

    assign w_valid  = (r_count != '0);
    assign w_full   = (r_count == CW'(UPD_DEPTH));
    assign w_pop    = w_valid & updReady_i;
    // A full FIFO still takes a push when the head leaves the same cycle
    assign w_pushOk = w_accept & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_memPC[r_wptr]   <= pc_i;
            r_memTgt[r_wptr]  <= nextPC_i;
            r_memDir[r_wptr]  <= flags_i[2] ? direction_i : 1'b1;
            r_memCond[r_wptr] <= flags_i[2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushOk) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            unique case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_accept & w_full & ~w_pop) r_overflow <= 1'b1;
        end
    end

    assign updValid_o  = w_valid;
    assign updPC_o     = w_valid ? r_memPC[r_rptr]   : '0;
    assign updTarget_o = w_valid ? r_memTgt[r_rptr]  : '0;
    assign updDir_o    = w_valid & r_memDir[r_rptr];
    assign updCond_o   = w_valid & r_memCond[r_rptr];
    assign updCount_o  = r_count;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_ctrl_resolve.sv
// Directed bench for ctrl_resolve: redirect timing, wrong-path drop,
// FIFO overflow/wrap, and reset during redirect.
module tb_ctrl_resolve;

    logic        clk = 0;
    logic        reset;
    logic        exeValid_i;
    logic [31:0] pc_i;
    logic [31:0] nextPC_i;
    logic        direction_i;
    logic [7:0]  flags_i;
    logic [6:0]  robId_i;
    logic [3:0]  ctiId_i;
    logic        recoverFlag_o;
    logic [31:0] recoverPC_o;
    logic [6:0]  recoverRobId_o;
    logic [3:0]  recoverCtiId_o;
    logic        squash_o;
    logic        updValid_o;
    logic [31:0] updPC_o;
    logic [31:0] updTarget_o;
    logic        updDir_o;
    logic        updCond_o;
    logic        updReady_i;
    logic [2:0]  updCount_o;
    logic        overflow_o;

    ctrl_resolve dut (
        .clk(clk), .reset(reset),
        .exeValid_i(exeValid_i), .pc_i(pc_i), .nextPC_i(nextPC_i),
        .direction_i(direction_i), .flags_i(flags_i),
        .robId_i(robId_i), .ctiId_i(ctiId_i),
        .recoverFlag_o(recoverFlag_o), .recoverPC_o(recoverPC_o),
        .recoverRobId_o(recoverRobId_o), .recoverCtiId_o(recoverCtiId_o),
        .squash_o(squash_o), .updValid_o(updValid_o),
        .updPC_o(updPC_o), .updTarget_o(updTarget_o),
        .updDir_o(updDir_o), .updCond_o(updCond_o),
        .updReady_i(updReady_i), .updCount_o(updCount_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        dir;
        logic        cond;
    } ent_t;

    ent_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Any handshake pop happening at the coming edge is scored first
    task automatic tick();
        ent_t e;
        if (updValid_o && updReady_i) begin
            if (sb.size() == 0) begin
                n_total++;
                $error("FAIL sb_underflow observed=%0h expected=none", updPC_o);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", updPC_o, e.pc);
                chk("pop_tgt", updTarget_o, e.tgt);
                chk("pop_dir", updDir_o, e.dir);
                chk("pop_cond", updCond_o, e.cond);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] npc,
                         input logic dir, input logic [7:0] fl,
                         input logic [6:0] rob, input logic [3:0] cti,
                         input logic exp_push);
        ent_t e;
        exeValid_i  = 1'b1;
        pc_i        = pc;
        nextPC_i    = npc;
        direction_i = dir;
        flags_i     = fl;
        robId_i     = rob;
        ctiId_i     = cti;
        if (exp_push) begin
            e.pc   = pc;
            e.tgt  = npc;
            e.dir  = fl[2] ? dir : 1'b1;
            e.cond = fl[2];
            sb.push_back(e);
        end
    endtask

    task automatic idle_in();
        exeValid_i = 1'b0;
        flags_i    = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        exeValid_i = 0; pc_i = 0; nextPC_i = 0; direction_i = 0;
        flags_i = 0; robId_i = 0; ctiId_i = 0; updReady_i = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_recFlag", recoverFlag_o, 0);
        chk("rst_recPC", recoverPC_o, 0);
        chk("rst_squash", squash_o, 0);
        chk("rst_valid", updValid_o, 0);
        chk("rst_updPC", updPC_o, 0);
        chk("rst_count", updCount_o, 0);
        chk("rst_ovf", overflow_o, 0);

        // correct prediction
        drive(32'h400100, 32'h400108, 1'b0, 8'h24, 7'd1, 4'd1, 1'b1);
        tick();
        chk("cp_valid", updValid_o, 1);
        chk("cp_pc", updPC_o, 32'h400100);
        chk("cp_tgt", updTarget_o, 32'h400108);
        chk("cp_dir", updDir_o, 0);
        chk("cp_cond", updCond_o, 1);
        chk("cp_recFlag", recoverFlag_o, 0);
        chk("cp_squash", squash_o, 0);

        // mispredict; input held valid so later cycles are wrong-path
        drive(32'h400104, 32'h400200, 1'b1, 8'h25, 7'd5, 4'd3, 1'b1);
        tick();
        chk("mp_recFlag", recoverFlag_o, 1);
        chk("mp_recPC", recoverPC_o, 32'h400200);
        chk("mp_recRob", recoverRobId_o, 5);
        chk("mp_recCti", recoverCtiId_o, 3);
        chk("mp_squash1", squash_o, 1);
        chk("mp_count", updCount_o, 2);
        drive(32'h400300, 32'h400400, 1'b1, 8'h25, 7'd9, 4'd7, 1'b0);
        tick();
        chk("dr1_recFlag", recoverFlag_o, 0);
        chk("dr1_squash", squash_o, 1);
        chk("dr1_count", updCount_o, 2);
        tick();
        chk("dr2_recFlag", recoverFlag_o, 0);
        chk("dr2_squash", squash_o, 1);
        chk("dr2_count", updCount_o, 2);
        idle_in();
        tick();
        chk("end_squash", squash_o, 0);
        chk("end_recFlag", recoverFlag_o, 0);
        chk("end_recPC", recoverPC_o, 32'h400200);
        chk("end_recRob", recoverRobId_o, 5);
        chk("end_count", updCount_o, 2);

        updReady_i = 1'b1;
        tick();
        tick();
        chk("drain_count", updCount_o, 0);
        chk("drain_valid", updValid_o, 0);
        tick();
        chk("empty_ready", updCount_o, 0);

        // fill past capacity; unconditional ops force dir=1
        updReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h600000 + 32'(i * 4), 32'h700000 + 32'(i * 16),
                  1'b0, 8'h20, 7'(i), 4'(i), 1'b1);
            tick();
        end
        chk("fill_count", updCount_o, 4);
        chk("fill_ovf", overflow_o, 0);
        chk("fill_head", updPC_o, 32'h600000);
        drive(32'h600010, 32'h777000, 1'b0, 8'h21, 7'd42, 4'd9, 1'b0);
        tick();
        chk("ovf_count", updCount_o, 4);
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_recFlag", recoverFlag_o, 1);
        chk("ovf_recPC", recoverPC_o, 32'h777000);
        chk("ovf_recRob", recoverRobId_o, 42);
        idle_in();
        repeat (3) tick();
        chk("ovf_squash", squash_o, 0);
        chk("stall_head", updPC_o, 32'h600000);
        chk("stall_dir", updDir_o, 1);
        chk("stall_cond", updCond_o, 0);

        // full: push and pop same cycle
        updReady_i = 1'b1;
        drive(32'h800000, 32'h800040, 1'b1, 8'h24, 7'd3, 4'd2, 1'b1);
        tick();
        idle_in();
        chk("pp_count", updCount_o, 4);
        chk("pp_ovf", overflow_o, 1);
        chk("pp_head", updPC_o, 32'h600004);
        repeat (4) tick();
        chk("pp_empty", updCount_o, 0);
        chk("sb_empty", sb.size(), 0);

        // reset during REDIRECT
        updReady_i = 1'b0;
        drive(32'h900000, 32'h900100, 1'b1, 8'h25, 7'd11, 4'd4, 1'b0);
        tick();
        idle_in();
        chk("pre_rst_flag", recoverFlag_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_squash", squash_o, 0);
        chk("rr_recFlag", recoverFlag_o, 0);
        chk("rr_count", updCount_o, 0);
        chk("rr_valid", updValid_o, 0);
        chk("rr_ovf", overflow_o, 0);
        chk("rr_recPC", recoverPC_o, 0);
        tick();
        chk("rr_idle", squash_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ctrl_resolve.md
Name: ctrl_resolve

Overview:
- Sits directly downstream of the control-transfer ALU in the execute stage. Consumes its per-instruction outputs: pc, nextPC, direction, and the 8-bit execution flags.
- Generates a registered front-end redirect on a branch/jump mispredict, with a fixed squash window after it.
- Queues every resolved control instruction into a small FIFO. The FIFO drains to the branch-predictor/BTB update port under a valid/ready handshake.

Parameters:
- SIZE_PC, 32, width of PC and target fields
- SIZE_ROB_LOG, 7, width of ROB index
- SIZE_CTI_LOG, 4, width of control-transfer-instruction queue index
- UPD_DEPTH, 4, predictor-update FIFO entries (power of 2, at least 2)
- DRAIN_CYCLES, 2, squash cycles after the redirect pulse (at least 1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exeValid_i  in  1  execute-stage result valid this cycle
- pc_i  in  SIZE_PC  PC of resolved instruction
- nextPC_i  in  SIZE_PC  computed next PC from ALU
- direction_i  in  1  computed branch direction
- flags_i  in  8  ALU flags: [0] mispredict, [2] conditional branch, [3] link write, [5] control op
- robId_i  in  SIZE_ROB_LOG  ROB index of instruction
- ctiId_i  in  SIZE_CTI_LOG  CTI queue index of instruction
- recoverFlag_o  out  1  one-cycle redirect pulse
- recoverPC_o  out  SIZE_PC  redirect target
- recoverRobId_o  out  SIZE_ROB_LOG  ROB index of mispredicting instruction
- recoverCtiId_o  out  SIZE_CTI_LOG  CTI index of mispredicting instruction
- squash_o  out  1  high while recovery is in progress
- updValid_o  out  1  FIFO head valid
- updPC_o  out  SIZE_PC  head PC
- updTarget_o  out  SIZE_PC  head target
- updDir_o  out  1  head direction
- updCond_o  out  1  head is a conditional branch
- updReady_i  in  1  predictor accepts head this cycle
- updCount_o  out  log2(UPD_DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky: a push was dropped

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-high.
  - On reset, every output is 0, the FIFO is empty (pointers 0), the FSM is in IDLE, and overflow_o is cleared.
  - Reset overrides all same-cycle activity, including an in-progress redirect or drain.
- Accept condition:
  - accept = exeValid_i & flags_i[5] & (state==IDLE).
  - Results arriving while state is not IDLE are wrong-path. They are discarded entirely: no push and no recovery.
- Recovery FSM, states IDLE, REDIRECT, DRAIN:
  - IDLE to REDIRECT when accept & flags_i[0]. In that same edge, latch recoverPC_o=nextPC_i, recoverRobId_o=robId_i, recoverCtiId_o=ctiId_i.
  - REDIRECT lasts exactly 1 cycle, with recoverFlag_o=1. It always goes to DRAIN and loads drainCnt=DRAIN_CYCLES-1.
  - DRAIN decrements drainCnt each cycle and returns to IDLE after the cycle with drainCnt==0.
  - squash_o = (state != IDLE).
  - Redirect latency: mispredict presented in cycle N, recoverFlag_o high in cycle N+1, squash_o high in cycles N+1 through N+1+DRAIN_CYCLES. A new mispredict can be accepted at cycle N+2+DRAIN_CYCLES.
  - recoverPC/RobId/CtiId hold their values until the next redirect.
- Update FIFO:
  - Push on every accept, whether or not the instruction mispredicted.
  - Entry contents: PC=pc_i, target=nextPC_i, dir = flags_i[2] ? direction_i : 1, cond=flags_i[2].
  - Pop when updValid_o & updReady_i. Outputs are driven from the head entry; a push into an empty FIFO becomes visible the next cycle.
  - Read and write pointers wrap modulo UPD_DEPTH. Full and empty are distinguished by occupancy count.
  - Push and pop in the same cycle: allowed at any occupancy, including full. Count is unchanged and there is no overflow.
  - Push while full without a pop: the entry is dropped, overflow_o sets and stays set until reset, and the FSM still honours the mispredict.
  - updReady_i while empty: no effect.
  - Head outputs stay stable while updValid_o & !updReady_i.

Test Plan:
- Reset, then an idle cycle: all outputs 0, updCount_o=0.
- Correct prediction, then redirect:
  - Stimulus: exeValid_i=1, flags_i=8'h24, pc_i=0x400100, nextPC_i=0x400108, direction_i=0, updReady_i=0.
  - Response: next cycle updValid_o=1, updPC_o=0x400100, updTarget_o=0x400108, updDir_o=0, updCond_o=1; recoverFlag_o stays 0.
  - Then mispredict flags_i=8'h25, nextPC_i=0x400200, robId_i=5: recoverFlag_o=1 for exactly 1 cycle with recoverPC_o=0x400200, recoverRobId_o=5; squash_o high for 3 cycles (DRAIN_CYCLES=2).
- Valid control result during DRAIN: no push, updCount_o unchanged, no second recoverFlag_o pulse.
- Five accepted pushes with updReady_i=0 (UPD_DEPTH=4): updCount_o=4, overflow_o=1 after the 5th. Then updReady_i=1 pops the 4 entries in push order.
- Full FIFO, simultaneous push and pop: count stays 4, overflow_o unchanged, the new entry lands at the tail and pointers wrap correctly.
- Reset asserted on the REDIRECT cycle: next cycle squash_o=0, recoverFlag_o=0, FIFO empty.
